// File: rtl/clock_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : clock_pkg
//  Purpose  : Shared types, BCD limits and increment helpers for the
//             alarm-clock set-mode controller.
//  Revision : 1.0  initial release
// ============================================================================
package clock_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_EDIT_HH = 3'd1,
    ST_EDIT_MM = 3'd2,
    ST_EDIT_SS = 3'd3,
    ST_EDIT_PM = 3'd4,
    ST_COMMIT  = 3'd5
  } fsm_state_e;

  typedef enum logic [1:0] {
    FLD_HH = 2'd0,
    FLD_MM = 2'd1,
    FLD_SS = 2'd2,
    FLD_PM = 2'd3
  } field_e;

  localparam logic [7:0] HR_MIN = 8'h01;
  localparam logic [7:0] HR_MAX = 8'h12;
  localparam logic [7:0] MS_MAX = 8'h59;

  // 12-hour BCD step: 12 wraps to 01, low digit 9 carries.
  function automatic logic [7:0] bcd_inc_hh(input logic [7:0] v);
    if (v == HR_MAX)          return HR_MIN;
    else if (v[3:0] == 4'h9)  return {v[7:4] + 4'h1, 4'h0};
    else                      return v + 8'h01;
  endfunction

  // Minute/second BCD step: 59 wraps to 00, low digit 9 carries.
  function automatic logic [7:0] bcd_inc_ms(input logic [7:0] v);
    if (v == MS_MAX)          return 8'h00;
    else if (v[3:0] == 4'h9)  return {v[7:4] + 4'h1, 4'h0};
    else                      return v + 8'h01;
  endfunction

endpackage
`default_nettype wire

// File: rtl/btn_edge_repeat.sv
`default_nettype none
// ============================================================================
//  Module   : btn_edge_repeat
//  Purpose  : Rising-edge detector with auto-repeat for a debounced button.
//             'rise' pulses on each press; 'step' adds repeat pulses while
//             the button stays held and 'enable' is high.
//  Revision : 1.0  initial release
// ============================================================================
module btn_edge_repeat #(
  parameter int REPEAT_DLY  = 50,
  parameter int REPEAT_RATE = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  input  logic enable,
  output logic rise,
  output logic step
);

  localparam int MAXC = (REPEAT_DLY > REPEAT_RATE) ? REPEAT_DLY : REPEAT_RATE;
  localparam int CW   = $clog2(MAXC + 1);

  logic          btn_q;
  logic          in_rep;
  logic [CW-1:0] cnt;
  logic          fire;

  // cnt is nonzero only after a real press, so a level held through reset
  // can never arm the repeat logic.
  assign rise = btn & ~btn_q;
  assign fire = btn & btn_q & (cnt != '0) &
                (in_rep ? (cnt == CW'(REPEAT_RATE)) : (cnt == CW'(REPEAT_DLY)));
  assign step = rise | (fire & enable);

  // Track previous level and count held cycles (delay phase, then rate phase).
  always_ff @(posedge clk) begin
    btn_q <= btn;
    if (reset) begin
      cnt    <= '0;
      in_rep <= 1'b0;
    end else if (!btn) begin
      cnt    <= '0;
      in_rep <= 1'b0;
    end else if (rise) begin
      cnt    <= CW'(1);
      in_rep <= 1'b0;
    end else if (cnt != '0) begin
      if (fire) begin
        cnt    <= CW'(1);
        in_rep <= 1'b1;
      end else begin
        cnt    <= cnt + CW'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/clock_set_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : clock_set_ctrl
//  Purpose  : Front-panel set-mode controller. Edits hh/mm/ss/pm in BCD,
//             seeds from live time or the alarm shadow, then drives the
//             load buses with a stretched load_time / load_alarm strobe.
//  Revision : 1.0  initial release
// ============================================================================
module clock_set_ctrl
  import clock_pkg::*;
#(
  parameter int LOAD_HOLD    = 16,
  parameter int REPEAT_DLY   = 50,
  parameter int REPEAT_RATE  = 10,
  parameter int IDLE_TIMEOUT = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_1s,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       btn_sel,
  input  logic [7:0] cur_hh,
  input  logic [7:0] cur_mm,
  input  logic [7:0] cur_ss,
  input  logic       cur_pm,
  output logic [7:0] hh_load,
  output logic [7:0] mm_load,
  output logic [7:0] ss_load,
  output logic       pm_load,
  output logic       load_time,
  output logic       load_alarm,
  output logic       editing,
  output logic [1:0] edit_field
);

  localparam int TW = $clog2(IDLE_TIMEOUT + 1);
  localparam int HW = $clog2(LOAD_HOLD + 1);

  fsm_state_e    state, state_n;
  logic          mode_q, mode_rise;
  logic          inc_rise, inc_step;
  logic          in_edit, timeout_hit, hold_done;
  logic          target;
  logic [7:0]    e_hh, e_mm, e_ss;
  logic          e_pm;
  logic [7:0]    sh_hh, sh_mm, sh_ss;
  logic          sh_pm;
  logic [TW-1:0] tcnt;
  logic [HW-1:0] hcnt;

  btn_edge_repeat #(
    .REPEAT_DLY  (REPEAT_DLY),
    .REPEAT_RATE (REPEAT_RATE)
  ) u_inc (
    .clk    (clk),
    .reset  (reset),
    .btn    (btn_inc),
    .enable (in_edit),
    .rise   (inc_rise),
    .step   (inc_step)
  );

  assign mode_rise   = btn_mode & ~mode_q;
  assign in_edit     = (state == ST_EDIT_HH) || (state == ST_EDIT_MM) ||
                       (state == ST_EDIT_SS) || (state == ST_EDIT_PM);
  // A button edge in the same cycle as the final tick keeps the edit alive.
  assign timeout_hit = in_edit & tick_1s & ~mode_rise & ~inc_rise &
                       (tcnt == TW'(IDLE_TIMEOUT - 1));
  assign hold_done   = (hcnt == HW'(LOAD_HOLD - 1));

  assign hh_load = e_hh;
  assign mm_load = e_mm;
  assign ss_load = e_ss;
  assign pm_load = e_pm;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_n;
  end

  // Next-state decode and state-derived outputs.
  always_comb begin
    state_n    = state;
    editing    = in_edit;
    edit_field = FLD_HH;
    load_time  = 1'b0;
    load_alarm = 1'b0;
    case (state)
      ST_IDLE:    if (mode_rise) state_n = ST_EDIT_HH;
      ST_EDIT_HH: begin
        edit_field = FLD_HH;
        if (mode_rise)        state_n = ST_EDIT_MM;
        else if (timeout_hit) state_n = ST_IDLE;
      end
      ST_EDIT_MM: begin
        edit_field = FLD_MM;
        if (mode_rise)        state_n = ST_EDIT_SS;
        else if (timeout_hit) state_n = ST_IDLE;
      end
      ST_EDIT_SS: begin
        edit_field = FLD_SS;
        if (mode_rise)        state_n = ST_EDIT_PM;
        else if (timeout_hit) state_n = ST_IDLE;
      end
      ST_EDIT_PM: begin
        edit_field = FLD_PM;
        if (mode_rise)        state_n = ST_COMMIT;
        else if (timeout_hit) state_n = ST_IDLE;
      end
      ST_COMMIT: begin
        load_time  = ~target;
        load_alarm = target;
        if (hold_done) state_n = ST_IDLE;
      end
      default:    state_n = ST_IDLE;
    endcase
  end

  // Mode-button level history; sampled during reset so a held level is no edge.
  always_ff @(posedge clk) begin
    mode_q <= btn_mode;
  end

  // Edit registers, target latch and alarm shadow.
  always_ff @(posedge clk) begin
    if (reset) begin
      target <= 1'b0;
      e_hh   <= HR_MAX;
      e_mm   <= 8'h00;
      e_ss   <= 8'h00;
      e_pm   <= 1'b0;
      sh_hh  <= HR_MAX;
      sh_mm  <= 8'h00;
      sh_ss  <= 8'h00;
      sh_pm  <= 1'b0;
    end else begin
      if (state == ST_IDLE && mode_rise) begin
        target <= btn_sel;
        e_hh   <= btn_sel ? sh_hh : cur_hh;
        e_mm   <= btn_sel ? sh_mm : cur_mm;
        e_ss   <= btn_sel ? sh_ss : cur_ss;
        e_pm   <= btn_sel ? sh_pm : cur_pm;
      end else if (in_edit && inc_step && !mode_rise) begin
        case (state)
          ST_EDIT_HH: e_hh <= bcd_inc_hh(e_hh);
          ST_EDIT_MM: e_mm <= bcd_inc_ms(e_mm);
          ST_EDIT_SS: e_ss <= bcd_inc_ms(e_ss);
          ST_EDIT_PM: e_pm <= ~e_pm;
          default:    ;
        endcase
      end
      if (state == ST_COMMIT && hold_done && target) begin
        sh_hh <= e_hh;
        sh_mm <= e_mm;
        sh_ss <= e_ss;
        sh_pm <= e_pm;
      end
    end
  end

  // Inactivity timer (edit states only) and commit strobe-length counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      tcnt <= '0;
      hcnt <= '0;
    end else begin
      if (!in_edit || mode_rise || inc_rise || timeout_hit) tcnt <= '0;
      else if (tick_1s)                                     tcnt <= tcnt + TW'(1);
      if (state == ST_COMMIT && !hold_done) hcnt <= hcnt + HW'(1);
      else                                  hcnt <= '0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_clock_set_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_clock_set_ctrl
//  Purpose  : Scoreboard bench for clock_set_ctrl with a behavioural model
//             of the set-mode sequence (integer time fields, wrap rules).
//  Revision : 1.0  initial release
// ============================================================================
module tb_clock_set_ctrl;

  localparam int LOAD_HOLD    = 16;
  localparam int REPEAT_DLY   = 50;
  localparam int REPEAT_RATE  = 10;
  localparam int IDLE_TIMEOUT = 10;

  logic       clk = 1'b0;
  logic       reset, tick_1s, btn_mode, btn_inc, btn_sel;
  logic [7:0] cur_hh, cur_mm, cur_ss;
  logic       cur_pm;
  logic [7:0] hh_load, mm_load, ss_load;
  logic       pm_load, load_time, load_alarm, editing;
  logic [1:0] edit_field;

  clock_set_ctrl #(
    .LOAD_HOLD    (LOAD_HOLD),
    .REPEAT_DLY   (REPEAT_DLY),
    .REPEAT_RATE  (REPEAT_RATE),
    .IDLE_TIMEOUT (IDLE_TIMEOUT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .tick_1s    (tick_1s),
    .btn_mode   (btn_mode),
    .btn_inc    (btn_inc),
    .btn_sel    (btn_sel),
    .cur_hh     (cur_hh),
    .cur_mm     (cur_mm),
    .cur_ss     (cur_ss),
    .cur_pm     (cur_pm),
    .hh_load    (hh_load),
    .mm_load    (mm_load),
    .ss_load    (ss_load),
    .pm_load    (pm_load),
    .load_time  (load_time),
    .load_alarm (load_alarm),
    .editing    (editing),
    .edit_field (edit_field)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         tgt;
    logic [31:0] bus;
    int         len;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   passes = 0;
  int   n_pushed = 0;
  int   n_seen = 0;

  // Reference model: plain integers for the fields.
  int m_field;   // -1 idle, 0..3 = hh/mm/ss/pm
  int m_tgt, m_tcnt;
  int m_h, m_m, m_s, m_pm;
  int sh_h, sh_m, sh_s, sh_pm;
  int c_h, c_m, c_s, c_pm;

  function automatic logic [7:0] bcd(input int v);
    return 8'((v / 10) * 16 + (v % 10));
  endfunction

  function automatic logic [31:0] model_bus();
    return {bcd(m_h), bcd(m_m), bcd(m_s), 7'd0, 1'(m_pm)};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic check_regs(input string name);
    check({name, "_bus"}, {hh_load, mm_load, ss_load, 7'd0, pm_load}, model_bus());
    check({name, "_editing"}, editing, (m_field >= 0));
    check({name, "_field"}, edit_field, (m_field >= 0) ? m_field : 0);
  endtask

  task automatic model_reset();
    m_field = -1; m_tgt = 0; m_tcnt = 0;
    m_h = 12; m_m = 0; m_s = 0; m_pm = 0;
    sh_h = 12; sh_m = 0; sh_s = 0; sh_pm = 0;
  endtask

  task automatic model_inc();
    case (m_field)
      0: m_h = (m_h % 12) + 1;
      1: m_m = (m_m + 1) % 60;
      2: m_s = (m_s + 1) % 60;
      3: m_pm = 1 - m_pm;
      default: ;
    endcase
  endtask

  task automatic set_cur(input int h, input int m, input int s, input int pm);
    c_h = h; c_m = m; c_s = s; c_pm = pm;
    cur_hh = bcd(h); cur_mm = bcd(m); cur_ss = bcd(s); cur_pm = 1'(pm);
  endtask

  // Returns 1 when this mode press starts a commit.
  function automatic int model_mode();
    m_tcnt = 0;
    if (m_field < 0) begin
      m_tgt = btn_sel;
      if (m_tgt == 1) begin m_h = sh_h; m_m = sh_m; m_s = sh_s; m_pm = sh_pm; end
      else            begin m_h = c_h;  m_m = c_m;  m_s = c_s;  m_pm = c_pm;  end
      m_field = 0;
      return 0;
    end else if (m_field < 3) begin
      m_field++;
      return 0;
    end
    q.push_back('{tgt: m_tgt, bus: model_bus(), len: LOAD_HOLD});
    n_pushed++;
    if (m_tgt == 1) begin sh_h = m_h; sh_m = m_m; sh_s = m_s; sh_pm = m_pm; end
    m_field = -1;
    return 1;
  endfunction

  task automatic press_mode();
    int c;
    btn_mode = 1'b1;
    @(posedge clk); #1;
    btn_mode = 1'b0;
    c = model_mode();
    @(posedge clk); #1;
    if (c != 0) begin
      repeat (LOAD_HOLD + 2) @(posedge clk);
      #1;
    end
  endtask

  task automatic press_inc();
    btn_inc = 1'b1;
    @(posedge clk); #1;
    btn_inc = 1'b0;
    if (m_field >= 0) begin model_inc(); m_tcnt = 0; end
    @(posedge clk); #1;
  endtask

  // Held n cycles: one press step, then repeats at held cycle DLY+1, +RATE, ...
  task automatic hold_inc(input int n);
    int steps;
    btn_inc = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    btn_inc = 1'b0;
    steps = 1 + ((n > REPEAT_DLY) ? ((n - REPEAT_DLY - 1) / REPEAT_RATE + 1) : 0);
    if (m_field >= 0) begin
      for (int k = 0; k < steps; k++) model_inc();
      m_tcnt = 0;
    end
    @(posedge clk); #1;
  endtask

  task automatic tick();
    tick_1s = 1'b1;
    @(posedge clk); #1;
    tick_1s = 1'b0;
    if (m_field >= 0) begin
      m_tcnt++;
      if (m_tcnt == IDLE_TIMEOUT) begin m_field = -1; m_tcnt = 0; end
    end
  endtask

  // Commit monitor: pops the expected load on each strobe and times it.
  initial begin
    exp_t        e;
    logic [31:0] cap;
    logic [1:0]  kind;
    int          len, stable;
    forever begin
      @(negedge clk);
      if (load_time || load_alarm) begin
        n_seen++;
        check("strobe_expected", (q.size() > 0), 1);
        if (q.size() > 0) e = q.pop_front();
        else e = '{tgt: 0, bus: 32'd0, len: 0};
        kind = {load_time, load_alarm};
        check("strobe_kind", kind, (e.tgt == 1) ? 2'b01 : 2'b10);
        cap = {hh_load, mm_load, ss_load, 7'd0, pm_load};
        check("commit_bus", cap, e.bus);
        len = 1; stable = 1;
        @(negedge clk);
        while (load_time || load_alarm) begin
          len++;
          if ({hh_load, mm_load, ss_load, 7'd0, pm_load} != cap) stable = 0;
          if ({load_time, load_alarm} != kind) stable = 0;
          @(negedge clk);
        end
        check("strobe_len", len, e.len);
        check("strobe_stable", stable, 1);
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int r, c;
    reset = 1'b1; tick_1s = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0; btn_sel = 1'b0;
    set_cur(11, 59, 58, 1);
    model_reset();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check_regs("reset");
    check("reset_strobes", {load_time, load_alarm}, 2'b00);

    // Time commit of live time, no increments.
    btn_sel = 1'b0;
    repeat (5) press_mode();
    check_regs("time_commit");

    // Alarm edit: hh 12->01, mm +60 wraps to 00.
    btn_sel = 1'b1;
    press_mode();
    press_inc();
    check("hh_step", hh_load, 8'h01);
    press_mode();
    for (int i = 0; i < 60; i++) press_inc();
    check_regs("mm_wrap");
    repeat (3) press_mode();

    // New alarm edit seeds from shadow; hold inc in ss.
    press_mode();
    check_regs("alarm_seed");
    press_mode();
    press_mode();
    hold_inc(REPEAT_DLY + REPEAT_RATE * 5);
    check("ss_repeat", ss_load, 8'h06);
    check_regs("hold");
    repeat (20) @(posedge clk);
    #1;
    check_regs("hold_release");
    press_mode();
    press_mode();

    // Timeout after IDLE_TIMEOUT ticks.
    btn_sel = 1'b0;
    press_mode();
    for (int i = 0; i < IDLE_TIMEOUT; i++) begin
      tick();
      check_regs("timeout");
    end

    // Simultaneous mode and inc edges in EDIT_MM.
    press_mode();
    press_inc();
    press_mode();
    btn_mode = 1'b1; btn_inc = 1'b1;
    @(posedge clk); #1;
    btn_mode = 1'b0; btn_inc = 1'b0;
    c = model_mode();
    @(posedge clk); #1;
    check_regs("mode_beats_inc");
    press_mode();
    press_mode();

    // Reset five cycles into a time commit.
    repeat (4) press_mode();
    btn_mode = 1'b1;
    @(posedge clk); #1;
    btn_mode = 1'b0;
    q.push_back('{tgt: m_tgt, bus: model_bus(), len: 5});
    n_pushed++;
    repeat (4) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    check("reset_drop_strobe", {load_time, load_alarm}, 2'b00);
    check_regs("reset_commit");
    btn_sel = 1'b1;
    press_mode();
    check_regs("shadow_reinit");
    repeat (4) press_mode();

    // Randomised operation mix.
    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 9);
      btn_sel = 1'($urandom_range(0, 1));
      set_cur($urandom_range(1, 12), $urandom_range(0, 59), $urandom_range(0, 59),
              $urandom_range(0, 1));
      if (r <= 3)      press_mode();
      else if (r <= 6) press_inc();
      else if (r <= 8) hold_inc($urandom_range(1, 75));
      else begin repeat ($urandom_range(1, 5)) @(posedge clk); #1; end
      check_regs("random");
    end
    while (m_field >= 0) press_mode();

    repeat (5) @(posedge clk);
    #1;
    check("commits_seen", n_seen, n_pushed);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
